fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory request at a
// time, buffers the returned word for decode, and handles branch redirects
// by discarding any fetch that is in flight or already buffered.
//
// Handshakes: a request transfers in the cycle imem_req_valid and
// imem_req_ready are both high; a buffered instruction transfers in the cycle
// instr_valid and instr_ready are both high. A valid, once raised, is held
// with stable payload until the transfer (or a redirect/reset) occurs.
// imem_rsp_valid is a single-cycle pulse with no back-pressure.
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    output logic        imem_req_valid,
    output logic [11:0] imem_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [15:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [11:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [11:0] pc, pc_nx;
    logic [11:0] req_pc, req_pc_nx;
    logic [15:0] instr_nx;
    logic [11:0] instr_pc_nx;

    // State and datapath registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= 12'h000;
            req_pc   <= 12'h000;
            instr    <= 16'h0000;
            instr_pc <= 12'h000;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_pc   <= req_pc_nx;
            instr    <= instr_nx;
            instr_pc <= instr_pc_nx;
        end
    end

    // Next-state logic; redirect is evaluated first in every state so it
    // overrides handshakes and responses arriving in the same cycle.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_pc_nx   = req_pc;
        instr_nx    = instr;
        instr_pc_nx = instr_pc;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_nx = redirect_pc;
                end else if (!halt) begin
                    state_nx = S_REQ;
                end
            end
            S_REQ: begin
                // halt is not looked at here: an asserted request stays up.
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    // An accepted request still owes a response that must be eaten.
                    state_nx = imem_req_ready ? S_DROP : S_IDLE;
                end else if (imem_req_ready) begin
                    req_pc_nx = pc;
                    pc_nx     = pc + 12'd1;
                    state_nx  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    // A response in this very cycle is the one being discarded.
                    state_nx = imem_rsp_valid ? S_IDLE : S_DROP;
                end else if (imem_rsp_valid) begin
                    instr_nx    = imem_rsp_data;
                    instr_pc_nx = req_pc;
                    state_nx    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    state_nx = S_IDLE;
                end else if (instr_ready) begin
                    state_nx = S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_nx = redirect_pc;
                    // Leave once the stale response has shown up, so we never wait forever.
                    if (imem_rsp_valid) begin
                        state_nx = S_IDLE;
                    end
                end else if (imem_rsp_valid) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;
    assign instr_valid    = (state == S_HOLD);
    assign fsm_state      = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus randomized traffic
// checked against a transaction-level model (sequential fetch addresses, a
// memory image, and a queue of delivered-but-unconsumed fetch addresses).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        imem_req_valid;
    logic [11:0] imem_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [4096];
    logic [11:0] exp_pc;
    logic [11:0] exp_q [$];

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fsm_state      (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        halt           = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        instr_ready    = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 12'h000;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_pc = 12'h000;
    endtask

    // Reset, then redirect while idle so the first request goes to 'a'.
    task automatic reset_to(input logic [11:0] a);
        do_reset();
        redirect    = 1'b1;
        redirect_pc = a;
        tick();
        redirect = 1'b0;
        exp_pc   = a;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 12'h000)
            $display("FAIL reset_values: req_valid=%b instr_valid=%b instr=%h instr_pc=%h, required 0/0/0000/000",
                     imem_req_valid, instr_valid, instr, instr_pc);
        else n_pass++;
        reset = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0)
            $display("FAIL reset_idle_cycle: req_valid=%b required 0", imem_req_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h000)
            $display("FAIL first_req: req_valid=%b addr=%h required 1/000", imem_req_valid, imem_addr);
        else n_pass++;
    endtask

    // Randomized traffic against the transaction model; drains before returning.
    task automatic run_traffic(input int cycles, input int rdy_pct, input int dmax,
                               input int ir_pct, input int halt_pct);
        bit          pend = 1'b0;
        int          cnt = 0;
        logic [11:0] pend_addr = '0;
        bit          prev_stall = 1'b0;
        logic [11:0] prev_addr = '0;
        bit          prev_hold = 1'b0;
        logic [15:0] hold_instr = '0;
        logic [11:0] hold_pc = '0;
        int          consumed = 0;
        logic [11:0] a;
        bit          drain;
        exp_q.delete();
        for (int c = 0; c < cycles + 30; c++) begin
            drain = (c >= cycles);
            if (prev_stall) begin
                n_checks++;
                if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr)
                    $display("FAIL req_hold: req_valid=%b addr=%h required 1/%h", imem_req_valid, imem_addr, prev_addr);
                else n_pass++;
            end
            if (prev_hold) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr !== hold_instr || instr_pc !== hold_pc)
                    $display("FAIL hold_stable: valid=%b instr=%h pc=%h required 1/%h/%h",
                             instr_valid, instr, instr_pc, hold_instr, hold_pc);
                else n_pass++;
            end
            if (imem_req_valid === 1'b1) begin
                n_checks++;
                if (pend || exp_q.size() != 0)
                    $display("FAIL one_outstanding: request raised with %0d in flight, required 0",
                             int'(pend) + exp_q.size());
                else n_pass++;
            end
            imem_req_ready = !drain && ($urandom_range(99) < rdy_pct);
            instr_ready    = drain || ($urandom_range(99) < ir_pct);
            halt           = !drain && ($urandom_range(99) < halt_pct);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'($urandom);
            if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem[pend_addr];
                    exp_q.push_back(pend_addr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                n_checks++;
                if (imem_addr !== exp_pc)
                    $display("FAIL fetch_addr: addr=%h required %h", imem_addr, exp_pc);
                else n_pass++;
                pend      = 1'b1;
                pend_addr = exp_pc;
                cnt       = $urandom_range(dmax, 0);
                exp_pc    = exp_pc + 12'd1;
            end
            if (instr_valid === 1'b1 && instr_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL instr_expected: instr %h pc %h delivered, required none", instr, instr_pc);
                end else begin
                    a = exp_q.pop_front();
                    if (instr_pc !== a || instr !== mem[a])
                        $display("FAIL instr_data: instr=%h pc=%h required %h/%h", instr, instr_pc, mem[a], a);
                    else n_pass++;
                end
                consumed++;
            end
            prev_stall = (imem_req_valid === 1'b1) && !imem_req_ready;
            prev_addr  = imem_addr;
            prev_hold  = (instr_valid === 1'b1) && !instr_ready;
            hold_instr = instr;
            hold_pc    = instr_pc;
            tick();
        end
        clear_inputs();
        n_checks++;
        if (pend || exp_q.size() != 0 || instr_valid !== 1'b0)
            $display("FAIL drain: pending=%0d instr_valid=%b required 0/0", int'(pend) + exp_q.size(), instr_valid);
        else n_pass++;
        n_checks++;
        if (consumed < 1)
            $display("FAIL progress: consumed=%0d required >=1", consumed);
        else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset();
        run_traffic(60, 100, 0, 100, 0);
    endtask

    task automatic test_wrap();
        reset_to(12'hFFD);
        run_traffic(30, 100, 0, 100, 0);
        n_checks++;
        if (exp_pc >= 12'hFFD || exp_pc == 12'h000)
            $display("FAIL wrap_progress: model pc=%h required wrapped past 000", exp_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        run_traffic(400, 60, 3, 60, 20);
        reset_to(12'($urandom));
        run_traffic(300, 40, 4, 50, 10);
    endtask

    task automatic test_redirect();
        // Redirect in WAIT: response dropped, refetch at target.
        reset_to(12'h040);
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h040)
            $display("FAIL redir_req0: valid=%b addr=%h required 1/040", imem_req_valid, imem_addr);
        else n_pass++;
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 12'h123; tick(); redirect = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL drop_quiet: instr_valid=%b req_valid=%b required 0/0", instr_valid, imem_req_valid);
        else n_pass++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'hBEEF; tick(); imem_rsp_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000)
            $display("FAIL drop_discard: instr_valid=%b instr=%h required 0/0000", instr_valid, instr);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h123)
            $display("FAIL redir_target: valid=%b addr=%h required 1/123", imem_req_valid, imem_addr);
        else n_pass++;

        // Redirect in WAIT with a same-cycle response: straight back to fetching.
        reset_to(12'h300);
        tick();
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 12'h0AA; imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1111;
        tick();
        redirect = 1'b0; imem_rsp_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0)
            $display("FAIL wait_rsp_redir: instr_valid=%b required 0", instr_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h0AA)
            $display("FAIL wait_rsp_refetch: valid=%b addr=%h required 1/0AA", imem_req_valid, imem_addr);
        else n_pass++;
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'h5A5A; tick(); imem_rsp_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h5A5A || instr_pc !== 12'h0AA)
            $display("FAIL refetch_data: valid=%b instr=%h pc=%h required 1/5A5A/0AA", instr_valid, instr, instr_pc);
        else n_pass++;

        // Redirect in REQ together with acceptance: the owed response is eaten.
        reset_to(12'h010);
        tick();
        imem_req_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h020; tick();
        imem_req_ready = 1'b0; redirect = 1'b0;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b0)
            $display("FAIL drop_waits: req_valid=%b required 0", imem_req_valid);
        else n_pass++;
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'h7777; tick(); imem_rsp_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0)
            $display("FAIL req_acc_redir_drop: instr_valid=%b required 0", instr_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h020)
            $display("FAIL req_acc_redir_target: valid=%b addr=%h required 1/020", imem_req_valid, imem_addr);
        else n_pass++;

        // Redirect in HOLD to the same PC: buffered word discarded, refetched.
        reset_to(12'h050);
        tick();
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1234; tick(); imem_rsp_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 12'h050)
            $display("FAIL hold_data: valid=%b instr=%h pc=%h required 1/1234/050", instr_valid, instr, instr_pc);
        else n_pass++;
        redirect = 1'b1; redirect_pc = 12'h050; instr_ready = 1'b1; tick();
        redirect = 1'b0; instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0)
            $display("FAIL hold_redir_clear: instr_valid=%b required 0", instr_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h050)
            $display("FAIL same_pc_refetch: valid=%b addr=%h required 1/050", imem_req_valid, imem_addr);
        else n_pass++;

        // Redirect in REQ without acceptance: back to idle, then fetch target.
        reset_to(12'h070);
        tick();
        redirect = 1'b1; redirect_pc = 12'h090; tick(); redirect = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0)
            $display("FAIL req_redir_idle: req_valid=%b required 0", imem_req_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h090)
            $display("FAIL req_redir_target: valid=%b addr=%h required 1/090", imem_req_valid, imem_addr);
        else n_pass++;
    endtask

    task automatic test_hold_stall();
        logic [15:0] d;
        d = 16'($urandom);
        reset_to(12'h200);
        tick();
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = d; tick(); imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== d || instr_pc !== 12'h200 || imem_req_valid !== 1'b0)
                $display("FAIL hold_stall: valid=%b instr=%h pc=%h req=%b required 1/%h/200/0",
                         instr_valid, instr, instr_pc, imem_req_valid, d);
            else n_pass++;
            tick();
        end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL hold_release_gap: instr_valid=%b req=%b required 0/0", instr_valid, imem_req_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 12'h201)
            $display("FAIL hold_next_req: valid=%b addr=%h required 1/201", imem_req_valid, imem_addr);
        else n_pass++;
    endtask

    task automatic test_halt_and_reset();
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (imem_req_valid !== 1'b0)
                $display("FAIL halt_idle: req_valid=%b required 0", imem_req_valid);
            else n_pass++;
        end
        halt = 1'b0; tick();
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 12'h000)
                $display("FAIL halt_req_held: valid=%b addr=%h required 1/000", imem_req_valid, imem_addr);
            else n_pass++;
            tick();
        end
        halt = 1'b0;
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0)
            $display("FAIL accept_drops_valid: req_valid=%b required 0", imem_req_valid);
        else n_pass++;
        reset = 1'b1; tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pc !== 12'h000)
            $display("FAIL reset_mid_fetch: req=%b valid=%b instr=%h pc=%h required 0/0/0000/000",
                     imem_req_valid, instr_valid, instr, instr_pc);
        else n_pass++;
        reset = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 16'hDEAD; tick(); imem_rsp_valid = 1'b0;
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000 || imem_req_valid !== 1'b1 || imem_addr !== 12'h000)
            $display("FAIL late_rsp_ignored: valid=%b instr=%h req=%b addr=%h required 0/0000/1/000",
                     instr_valid, instr, imem_req_valid, imem_addr);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_wrap();
        test_redirect();
        test_hold_stall();
        test_halt_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
